pt_frame_assembler: RTL
=======================

Name: pt_frame_assembler

Overview:
- Sits between the UART receiver byte stream and the PT2262 encoder (pt_enc).
- Collects three received bytes into one 24-bit address/data word, first byte in the MSBs.
- Guards frame assembly with an inter-byte timeout.
- Then runs the encoder for a fixed number of codeword repeats and releases it.
- Runs entirely in the encoder clock domain; its byte-valid input is already synchronised to that domain.

Parameters:
- TIMEOUT_CYCLES, 50: idle clk cycles allowed between bytes of one frame before the partial frame is discarded.
- REPEATS, 6: number of complete encoder codewords sent per frame.

Ports:
- clk  input  1  encoder-domain clock.
- rst  input  1  reset, asynchronous, active-low.
- in_valid  input  1  one-cycle pulse, in_data holds a new byte.
- in_data  input  8  received byte.
- in_ready  output  1  high when a byte can be accepted (IDLE or COLLECT).
- enc_done  input  1  pt_enc done level; each rising edge marks one finished codeword.
- payload  output  24  word presented to pt_enc ad.
- enc_run  output  1  high while the encoder must transmit; drives pt_enc reset inverted.
- busy  output  1  high in COLLECT or SEND.
- frame_err  output  1  one-cycle pulse when a partial frame times out.
- overrun  output  1  one-cycle pulse when in_valid arrives while in_ready is low.

Behaviour:
- Reset (rst low, asynchronous): all state cleared immediately; state is IDLE.
  - Output values in reset: payload=0, enc_run=0, busy=0, frame_err=0, overrun=0, in_ready=1.
  - Reset asserted mid-frame or mid-send aborts the operation; enc_run drops in the same instant.
- States: IDLE, COLLECT, SEND.
- IDLE:
  - in_valid: byte stored in shadow[23:16], byte index=1, timeout counter=0, go to COLLECT.
- COLLECT:
  - in_valid with index 1: byte stored in shadow[15:8], index=2, counter=0.
  - in_valid with index 2: byte stored in shadow[7:0]. Next cycle: payload<=full shadow, enc_run=1, repeat counter=0, state SEND.
  - Latency: third in_valid at cycle N gives payload valid and enc_run=1 at N+1.
  - Otherwise the timeout counter increments each cycle. When it reaches TIMEOUT_CYCLES-1 with no in_valid: shadow discarded, frame_err pulses for 1 cycle, state returns to IDLE. payload is not modified.
  - in_valid on the same cycle the counter expires: the byte wins. It is accepted, the counter clears and no frame_err is raised.
- SEND:
  - in_ready=0. payload is held stable for the whole state.
  - enc_done is registered once; a rising edge is detected as done_q=0 and enc_done=1.
  - enc_done high on entry to SEND does not count as an edge, because done_q is primed with the current enc_done at entry.
  - Each edge increments the repeat counter. On the edge that completes REPEATS codewords: enc_run=0 on the next cycle and state IDLE.
  - in_valid during SEND: byte dropped, overrun pulses 1 cycle, state is unaffected.
- Payload register:
  - Updated only on frame completion, never on partial frames.
  - Retains its last value in IDLE.
- Width rules:
  - Timeout counter width is clog2(TIMEOUT_CYCLES)+1.
  - Repeat counter width is clog2(REPEATS)+1.
  - Neither counter wraps: the timeout counter saturates at its expiry value; the repeat counter clears on entry to SEND.
- busy = (state != IDLE). in_ready = (state != SEND).

Test Plan:
- Bytes 0xA5, 0x3C, 0x0F, 5 cycles apart -> payload=0xA53C0F and enc_run=1 one cycle after the third byte.
  - Then 6 enc_done rising edges -> enc_run=0 the cycle after the 6th edge; state IDLE; busy=0.
- Bytes 0x11, 0x22, then silence -> frame_err pulses once at 50 cycles after 0x22; payload unchanged (0); in_ready=1.
  - A following 0x33, 0x44, 0x55 -> payload=0x334455.
- in_valid on the exact timeout-expiry cycle -> no frame_err; frame completes normally with 3 bytes total.
- in_valid pulse during SEND -> overrun pulse; payload unchanged; repeat count unaffected; exactly 6 codewords still sent.
- enc_done already high when SEND is entered -> not counted; 6 further rising edges are required to finish.
- rst low during SEND after 3 edges -> enc_run=0 immediately; payload=0.
  - After rst release, a new 3-byte frame runs a full 6 repeats.

Source files
------------

// File: rtl/pt_frame_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module      : pt_frame_assembler_if
//  Description : Byte-stream / encoder-control bundle for pt_frame_assembler.
//                slave  = the assembler itself (consumes bytes, drives pt_enc)
//                master = the environment (UART byte source, pt_enc status)
//  Signals     : in_valid/in_data/in_ready  byte stream handshake
//                enc_done                   pt_enc done level
//                payload/enc_run            pt_enc address/data and run enable
//                busy/frame_err/overrun     status
//  Revision    : 1.0  initial release
// ============================================================================
interface pt_frame_assembler_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        enc_done;
  logic [23:0] payload;
  logic        enc_run;
  logic        busy;
  logic        frame_err;
  logic        overrun;

  modport slave (
    input  in_valid, in_data, enc_done,
    output in_ready, payload, enc_run, busy, frame_err, overrun
  );

  modport master (
    output in_valid, in_data, enc_done,
    input  in_ready, payload, enc_run, busy, frame_err, overrun
  );
endinterface
`default_nettype wire

// File: rtl/pt_frame_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : pt_frame_assembler
//  Description : Collects three UART bytes (first byte in the MSBs) into a
//                24-bit PT2262 address/data word, guarded by an inter-byte
//                timeout, then runs pt_enc for REPEATS codewords.
//  Ports       : clk      encoder-domain clock
//                rst      asynchronous, active-low reset
//                bus      pt_frame_assembler_if.slave
//                  in_valid/in_data  byte pulse and data (already synchronised)
//                  in_ready          byte acceptable (IDLE or COLLECT)
//                  enc_done          pt_enc done level, rising edge = codeword
//                  payload           word presented to pt_enc ad
//                  enc_run           encoder transmit enable (pt_enc reset = ~)
//                  busy              COLLECT or SEND
//                  frame_err         1-cycle pulse, partial frame timed out
//                  overrun           1-cycle pulse, byte arrived while busy sending
//  Parameters  : TIMEOUT_CYCLES  idle cycles allowed between bytes of a frame
//                REPEATS         codewords sent per frame
//  Revision    : 1.0  initial release
// ============================================================================
module pt_frame_assembler #(
  parameter int TIMEOUT_CYCLES = 50,
  parameter int REPEATS        = 6
) (
  input  wire logic            clk,
  input  wire logic            rst,
  pt_frame_assembler_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int REP_W = $clog2(REPEATS) + 1;

  localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [REP_W-1:0] c_REP_LAST = REP_W'(REPEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SEND    = 2'd2
  } state_t;

  state_t            r_state,   w_state_nxt;
  logic [23:0]       r_shadow,  w_shadow_nxt;
  logic [1:0]        r_idx,     w_idx_nxt;
  logic [TMO_W-1:0]  r_tmo,     w_tmo_nxt;
  logic [REP_W-1:0]  r_rep,     w_rep_nxt;
  logic [23:0]       r_payload, w_payload_nxt;
  logic              r_frame_err, w_frame_err_nxt;
  logic              r_overrun,   w_overrun_nxt;
  logic              r_done_q;
  logic              w_done_rise;

  // r_done_q samples enc_done every cycle, so on the cycle SEND is entered it
  // already holds the level present at entry: a done level that is high when
  // sending starts is not mistaken for a finished codeword.
  assign w_done_rise = bus.enc_done & ~r_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_shadow    <= '0;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_rep       <= '0;
      r_payload   <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      r_done_q    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shadow    <= w_shadow_nxt;
      r_idx       <= w_idx_nxt;
      r_tmo       <= w_tmo_nxt;
      r_rep       <= w_rep_nxt;
      r_payload   <= w_payload_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overrun   <= w_overrun_nxt;
      r_done_q    <= bus.enc_done;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_shadow_nxt    = r_shadow;
    w_idx_nxt       = r_idx;
    w_tmo_nxt       = r_tmo;
    w_rep_nxt       = r_rep;
    w_payload_nxt   = r_payload;
    w_frame_err_nxt = 1'b0;
    w_overrun_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) begin
          w_shadow_nxt[23:16] = bus.in_data;
          w_idx_nxt           = 2'd1;
          w_tmo_nxt           = '0;
          w_state_nxt         = S_COLLECT;
        end
      end

      S_COLLECT: begin
        // A byte on the expiry cycle is checked first, so it beats the timeout.
        if (bus.in_valid) begin
          w_tmo_nxt = '0;
          if (r_idx == 2'd1) begin
            w_shadow_nxt[15:8] = bus.in_data;
            w_idx_nxt          = 2'd2;
          end else begin
            w_shadow_nxt[7:0] = bus.in_data;
            w_payload_nxt     = w_shadow_nxt;
            w_idx_nxt         = 2'd0;
            w_rep_nxt         = '0;
            w_state_nxt       = S_SEND;
          end
        end else if (r_tmo == c_TMO_LAST) begin
          w_shadow_nxt    = '0;
          w_idx_nxt       = 2'd0;
          w_tmo_nxt       = '0;
          w_frame_err_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end

      S_SEND: begin
        w_overrun_nxt = bus.in_valid;
        if (w_done_rise) begin
          w_rep_nxt = r_rep + REP_W'(1);
          if (r_rep == c_REP_LAST) begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // enc_run decodes straight from the state register so an asynchronous
  // reset stops the encoder in the same instant.
  assign bus.payload   = r_payload;
  assign bus.enc_run   = (r_state == S_SEND);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.in_ready  = (r_state != S_SEND);
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire
